inst_s_enc: RTL and testbench

- Streaming S-type (store) instruction encoder; the inverse of the S-type field decoder.
- Takes store operands (funct3, rs1, rs2, 12-bit immediate) over a valid/ready handshake.
- Packs them into a 32-bit RV32I S-format word and buffers the result in a 2-entry output queue.
- Each emitted word is tagged with a sequential instruction-memory byte address, so the block can feed an instruction-memory loader.

---
 rtl/inst_s_enc.sv | 101 ++++++++++
 tb/tb_inst_s_enc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_s_enc.sv
// rtl/inst_s_enc.sv - streaming RV32I S-type store encoder with 2-entry address-tagged output queue
module inst_s_enc #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [11:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [6:0]        OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  q_state_e          state_q, state_d;
  logic [31:0]       inst_mem_q [2];
  logic [ADDR_W-1:0] addr_mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  logic        legal, accept, push, pop;
  logic [31:0] enc_word;

  // Only SB/SH/SW widths are legal stores; anything above SW is rejected.
  assign legal    = (funct3 <= 3'b010);
  // Ready comes from registered state only, so a pop cannot open a full queue in the same cycle.
  assign in_ready  = ~rst & (state_q != Q_FULL);
  assign out_valid = (state_q != Q_EMPTY);
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal;
  assign pop      = out_valid & out_ready;
  assign enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};

  // Queue occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= Q_EMPTY;
    else     state_q <= state_d;
  end

  // Occupancy transitions; push and pop together in ONE keeps the count at one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Q_EMPTY: if (push) state_d = Q_ONE;
      Q_ONE: begin
        if (push && !pop)      state_d = Q_FULL;
        else if (pop && !push) state_d = Q_EMPTY;
      end
      Q_FULL:  if (pop) state_d = Q_ONE;
      default: state_d = Q_EMPTY;
    endcase
  end

  // Pointers, running address tag and the one-cycle illegal pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      addr_q   <= BASE;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
        addr_q   <= addr_q + STEP;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      err_q <= accept & ~legal;
    end
  end

  // Queue storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= enc_word;
      addr_mem_q[wr_ptr_q] <= addr_q;
    end
  end

  assign out_inst    = inst_mem_q[rd_ptr_q];
  assign out_addr    = addr_mem_q[rd_ptr_q];
  assign err_illegal = err_q;

endmodule

// File: tb/tb_inst_s_enc.sv
// tb/tb_inst_s_enc.sv - randomized and directed self-checking bench for inst_s_enc
module tb_inst_s_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [11:0] imm = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [9:0]  out_addr;
  logic        err_illegal;

  int errors = 0;
  int checks = 0;

  inst_s_enc #(.ADDR_W(10), .BASE_ADDR(0), .ADDR_STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int f3, input int r1, input int r2, input int im);
    longint w;
    w = (longint'((im / 32) % 128) * 33554432) + (longint'(r2) * 1048576) +
        (longint'(r1) * 32768) + (longint'(f3) * 4096) + (longint'(im % 32) * 128) + 35;
    return w[31:0];
  endfunction

  // Reference model: a plain FIFO of (word, address) plus an address counter.
  logic [31:0] mq_inst[$];
  int          mq_addr[$];
  int          m_addr = 0;
  bit          m_err = 0;
  int          popped[$];
  bit          s_valid = 0;
  int          s_addr = 0;
  bit          m_acc, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_inst.delete();
      mq_addr.delete();
      m_addr = 0;
      m_err  = 0;
    end else begin
      m_acc = in_valid && (mq_inst.size() < 2);
      m_pop = (mq_inst.size() > 0) && out_ready;
      if (m_pop) begin
        popped.push_back(s_valid ? s_addr : -1);
        void'(mq_inst.pop_front());
        void'(mq_addr.pop_front());
      end
      m_err = 0;
      if (m_acc) begin
        if (funct3 <= 3'd2) begin
          mq_inst.push_back(enc(int'(funct3), int'(rs1), int'(rs2), int'(imm)));
          mq_addr.push_back(m_addr);
          m_addr = (m_addr + 4) % 1024;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, mq_inst.size() > 0);
      chk("in_ready", in_ready, mq_inst.size() < 2);
      chk("err_illegal", err_illegal, m_err);
      if (mq_inst.size() > 0) begin
        chk("out_inst", out_inst, mq_inst[0]);
        chk("out_addr", out_addr, mq_addr[0]);
      end
      s_valid = out_valid;
      s_addr  = int'(out_addr);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  // Present one operand set and return at the negedge after it was accepted.
  task automatic push(input int f3, input int r1, input int r2, input int im);
    int n;
    bit acc;
    in_valid = 1'b1;
    funct3 = 3'(f3);
    rs1 = 5'(r1);
    rs2 = 5'(r2);
    imm = 12'(im);
    n = 0;
    acc = 0;
    while (!acc && n < 20) begin
      acc = in_ready;
      @(negedge clk);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    chk("model_enc_pin", enc(2, 13, 0, 'h0FD), 32'h0E06AEA3);
    do_reset();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_err", err_illegal, 0);
    chk("reset_in_ready", in_ready, 1);

    // First word and back-to-back pushes with no bubbles.
    out_ready = 1'b1;
    push(2, 13, 0, 'h0FD);
    chk("t1_valid", out_valid, 1);
    chk("t1_inst", out_inst, 32'h0E06AEA3);
    chk("t1_addr", out_addr, 0);
    push(2, 12, 21, 'h4AF);
    chk("t2_valid", out_valid, 1);
    chk("t2_inst", out_inst, 32'h4B5627A3);
    chk("t2_addr", out_addr, 4);
    push(2, 7, 11, 'h881);
    chk("t3_valid", out_valid, 1);
    chk("t3_inst", out_inst, 32'h88B3A0A3);
    chk("t3_addr", out_addr, 8);
    idle(2);

    // Backpressure: third word held until the consumer drains.
    do_reset();
    popped.delete();
    out_ready = 1'b0;
    push(0, 1, 2, 'h123);
    push(1, 3, 4, 'h456);
    in_valid = 1'b1; funct3 = 3'd2; rs1 = 5'd5; rs2 = 5'd6; imm = 12'h789;
    chk("full_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("full_held_ready", in_ready, 0);
    out_ready = 1'b1;
    push(2, 5, 6, 'h789);
    idle(4);
    chk("bp_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("bp_addr0", popped[0], 0);
      chk("bp_addr1", popped[1], 4);
      chk("bp_addr2", popped[2], 8);
    end

    // Illegal funct3 between two legal words.
    do_reset();
    popped.delete();
    out_ready = 1'b1;
    push(2, 1, 1, 1);
    push(3, 2, 2, 2);
    chk("ill_err_pulse", err_illegal, 1);
    push(0, 3, 3, 3);
    chk("ill_err_clear", err_illegal, 0);
    idle(3);
    chk("ill_count", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("ill_addr0", popped[0], 0);
      chk("ill_addr1", popped[1], 4);
    end

    // Address wrap at 2^10.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      push(i % 3, i % 32, (i * 7) % 32, (i * 13) % 4096);
      if (i == 255) chk("wrap_addr_1020", out_addr, 1020);
      if (i == 256) chk("wrap_addr_0", out_addr, 0);
    end
    idle(2);

    // Asynchronous reset with the queue full.
    out_ready = 1'b0;
    push(2, 9, 9, 9);
    push(2, 10, 10, 10);
    in_valid = 1'b0;
    chk("pre_rst_full_valid", out_valid, 1);
    chk("pre_rst_full_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_err", err_illegal, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    push(2, 4, 4, 4);
    chk("post_rst_addr", out_addr, 0);

    // Asynchronous reset while the illegal pulse is high.
    push(6, 1, 1, 1);
    in_valid = 1'b0;
    chk("pre_rst_err", err_illegal, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_err_drop", err_illegal, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      funct3    = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      rs1       = 5'($urandom);
      rs2       = 5'($urandom);
      imm       = 12'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
